// File: rtl/serial_add_seq_sar.sv
// serial_add_seq_sar
//   Wide adder sequencer: adds two 4*NIBBLES-bit operands plus a carry-in by
//   time-sharing one external 4-bit combinational adder, one nibble per
//   clock, least significant nibble first. The carry is chained through an
//   internal register. The result is reported with a one-cycle done pulse.
//
// Parameters
//   NIBBLES  number of 4-bit slices per operation (legal range 2..16)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (priority over start)
//   start     request, sampled only in IDLE or DONE
//   a_in      operand A, sampled with start
//   b_in      operand B, sampled with start
//   c_in      carry-in, sampled with start
//   busy      high while an operation is running
//   done      one-cycle pulse when sum_out/c_out are valid
//   sum_out   result (shows partial nibbles while busy)
//   c_out     final carry out of the wide addition
//   add_a     nibble of A to the shared adder (0 when not running)
//   add_b     nibble of B to the shared adder (0 when not running)
//   add_cin   carry into the shared adder (0 when not running)
//   add_sum   shared adder sum, combinational from add_a/add_b/add_cin
//   add_cout  shared adder carry out
module serial_add_seq_sar #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum_out,
  output logic                 c_out,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout
);

  localparam int W      = 4 * NIBBLES;
  localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int BASE_W = IDX_W + 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              carry_q;
  logic [W-1:0]      op_a_q;
  logic [W-1:0]      op_b_q;
  logic [W-1:0]      sum_q;
  logic              c_out_q;

  // Bit offset of the active nibble; idx*4 expressed as a concatenation
  // so the part-select index has exactly the width needed to address W.
  logic [BASE_W-1:0] nib_base;
  assign nib_base = {idx_q, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            op_a_q  <= a_in;
            op_b_q  <= b_in;
            carry_q <= c_in;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q[nib_base +: 4] <= add_sum;
          carry_q              <= add_cout;
          // idx stops on the last nibble instead of wrapping; it is
          // reloaded on the next accepted start anyway.
          if (idx_q == LAST_IDX) begin
            c_out_q <= add_cout;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Adder slice drive, decoded from registers only.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = op_a_q[nib_base +: 4];
      add_b   = op_b_q[nib_base +: 4];
      add_cin = carry_q;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign sum_out = sum_q;
  assign c_out   = c_out_q;

endmodule

// File: tb/tb_serial_add_seq_sar.sv
// Bench for serial_add_seq_sar with NIBBLES=4 and a behavioural 4-bit adder
// attached to the add_* ports. Expected results come from plain W+1-bit
// arithmetic on the operands.
module tb_serial_add_seq_sar;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         c_out;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  always #5 clk = ~clk;

  // Shared 4-bit adder slice.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  serial_add_seq_sar #(.NIBBLES(NIB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .c_out    (c_out),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        cin_seq [NIB];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},    64'(busy),    64'd0);
    chk({tag, "_done"},    64'(done),    64'd0);
    chk({tag, "_sum"},     64'(sum_out), 64'd0);
    chk({tag, "_cout"},    64'(c_out),   64'd0);
    chk({tag, "_add_a"},   64'(add_a),   64'd0);
    chk({tag, "_add_b"},   64'(add_b),   64'd0);
    chk({tag, "_add_cin"}, 64'(add_cin), 64'd0);
  endtask

  // One isolated operation. Inputs change on the falling edge; outputs are
  // sampled on the falling edge. With inject set, a second start with other
  // operands is raised during the second RUN cycle and must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input bit inject, input string tag);
    logic [W:0] ref_v;
    int         lat;
    int         busy_n;
    bit         seen;
    ref_v = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    @(negedge clk);
    a_in = a; b_in = b; c_in = c; start = 1'b1;
    lat = 0; busy_n = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (inject && lat == 2) begin
        start = 1'b1; a_in = ~a; b_in = a ^ 16'h5A5A; c_in = ~c;
      end
      if (inject && lat == 3) start = 1'b0;
      if (busy) begin
        if (busy_n < NIB) cin_seq[busy_n] = add_cin;
        busy_n++;
      end
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_latency"}, 64'(lat),     64'(NIB + 1));
      chk({tag, "_busy_n"},  64'(busy_n),  64'(NIB));
      chk({tag, "_sum"},     64'(sum_out), 64'(ref_v[W-1:0]));
      chk({tag, "_cout"},    64'(c_out),   64'(ref_v[W]));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(done),    64'd0);
      chk({tag, "_sum_hold"},   64'(sum_out), 64'(ref_v[W-1:0]));
    end
  endtask

  initial begin
    int          lat;
    int          n_done;
    bit          seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic        rc;

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, "t1");

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "t2");
    chk("t2_cin0", 64'(cin_seq[0]), 64'd0);
    chk("t2_cin1", 64'(cin_seq[1]), 64'd1);
    chk("t2_cin2", 64'(cin_seq[2]), 64'd1);
    chk("t2_cin3", 64'(cin_seq[3]), 64'd1);

    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, "t3");

    // Back-to-back with start held high.
    @(negedge clk);
    a_in = 16'h0001; b_in = 16'h0001; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    a_in = 16'h8000; b_in = 16'h8000;
    seen = 1'b0; lat = 1;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    chk("b2b_first_seen", 64'(seen), 64'd1);
    chk("b2b_first_lat",  64'(lat),  64'(NIB + 1));
    chk("b2b_first_sum",  64'(sum_out), 64'h0002);
    chk("b2b_first_cout", 64'(c_out),   64'd0);
    seen = 1'b0; lat = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("b2b_rerun_busy", 64'(busy), 64'd1);
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    chk("b2b_second_seen", 64'(seen),    64'd1);
    chk("b2b_second_lat",  64'(lat),     64'(NIB + 1));
    chk("b2b_second_sum",  64'(sum_out), 64'h0000);
    chk("b2b_second_cout", 64'(c_out),   64'd1);
    @(negedge clk);
    chk("b2b_idle_busy", 64'(busy), 64'd0);

    // Reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    a_in = 16'h1111; b_in = 16'h2222; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_zero("abort");
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("abort_no_done", 64'(n_done), 64'd0);
    run_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, "after_abort");

    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, 1'b0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
